// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchroniser, 3-sample majority per bit,
// optional parity, registered word/valid/error pulses.
module uart_rx #(
  parameter int unsigned DATA_LENGTH = 8,
  parameter int unsigned OVERSAMPLE  = 8
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   RX_IN,
  input  logic                   PAR_EN,
  input  logic                   PAR_TYP,
  output logic [DATA_LENGTH-1:0] P_DATA,
  output logic                   DATA_VALID,
  output logic                   PAR_ERR,
  output logic                   STP_ERR,
  output logic                   BUSY
);

  localparam int unsigned CNT_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam int unsigned BIT_W = (DATA_LENGTH > 1) ? $clog2(DATA_LENGTH) : 1;

  localparam logic [CNT_W-1:0] OFS_S0   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] OFS_S1   = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] OFS_DEC  = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] OFS_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_LENGTH - 1);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

  state_t                 state_q, state_d;
  logic                   rx_meta_q, rx_s_q;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bit_q, bit_d;
  logic                   s0_q, s0_d, s1_q, s1_d;
  logic [DATA_LENGTH-1:0] shreg_q, shreg_d;
  logic                   par_en_q, par_en_d, par_typ_q, par_typ_d;
  logic                   par_fail_q, par_fail_d;
  logic                   stop_bad_q, stop_bad_d;
  logic                   done_q, done_d;
  logic                   maj_c, last_c, dec_c, exp_par_c, good_c;

  // Two-flop synchroniser for the asynchronous line, idling high.
  always_ff @(posedge CLK) begin
    if (RST) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= RX_IN;
      rx_s_q    <= rx_meta_q;
    end
  end

  // Majority of the two earlier samples and the current one; decision helpers.
  always_comb begin
    maj_c     = (s0_q & s1_q) | (s0_q & rx_s_q) | (s1_q & rx_s_q);
    last_c    = (cnt_q == OFS_LAST);
    dec_c     = (cnt_q == OFS_DEC);
    exp_par_c = (^shreg_q) ^ par_typ_q;
    good_c    = done_q & ~stop_bad_q & ~par_fail_q;
  end

  // Next-state and datapath updates; cnt_q is the offset of the current edge within the bit.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    s0_d       = s0_q;
    s1_d       = s1_q;
    shreg_d    = shreg_q;
    par_en_d   = par_en_q;
    par_typ_d  = par_typ_q;
    par_fail_d = par_fail_q;
    stop_bad_d = stop_bad_q;
    done_d     = 1'b0;

    if (state_q != IDLE) begin
      cnt_d = last_c ? '0 : cnt_q + CNT_W'(1);
      if (cnt_q == OFS_S0) s0_d = rx_s_q;
      if (cnt_q == OFS_S1) s1_d = rx_s_q;
    end

    case (state_q)
      IDLE: begin
        if (!rx_s_q) begin
          state_d    = START;
          cnt_d      = CNT_W'(1);
          bit_d      = '0;
          par_en_d   = PAR_EN;
          par_typ_d  = PAR_TYP;
          par_fail_d = 1'b0;
          stop_bad_d = 1'b0;
        end
      end
      START: begin
        if (dec_c && maj_c) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (last_c) begin
          state_d = DATA;
        end
      end
      DATA: begin
        if (dec_c) shreg_d[bit_q] = maj_c;
        if (last_c) begin
          if (bit_q == BIT_LAST) state_d = par_en_q ? PARITY : STOP;
          else                   bit_d   = bit_q + BIT_W'(1);
        end
      end
      PARITY: begin
        if (dec_c && (maj_c != exp_par_c)) par_fail_d = 1'b1;
        if (last_c) state_d = STOP;
      end
      STOP: begin
        if (dec_c) begin
          stop_bad_d = ~maj_c;
          done_d     = 1'b1;
          state_d    = IDLE;
          cnt_d      = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      s0_q       <= 1'b1;
      s1_q       <= 1'b1;
      shreg_q    <= '0;
      par_en_q   <= 1'b0;
      par_typ_q  <= 1'b0;
      par_fail_q <= 1'b0;
      stop_bad_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      shreg_q    <= shreg_d;
      par_en_q   <= par_en_d;
      par_typ_q  <= par_typ_d;
      par_fail_q <= par_fail_d;
      stop_bad_q <= stop_bad_d;
      done_q     <= done_d;
    end
  end

  // Registered outputs; frame result pulses one cycle after the stop decision.
  always_ff @(posedge CLK) begin
    if (RST) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      DATA_VALID <= good_c;
      PAR_ERR    <= done_q & par_fail_q;
      STP_ERR    <= done_q & stop_bad_q;
      BUSY       <= (state_d != IDLE);
      if (good_c) P_DATA <= shreg_q;
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
Serial receiver that consumes the line driven by the UART transmit path and recovers parallel frames.
- Frame format: start bit (0), DATA_LENGTH data bits LSB first, optional parity bit, one stop bit (1). Matches the transmit path's frame.
- CLK is the oversampling clock: OVERSAMPLE CLK cycles per bit.
- Outputs: recovered word with a one-cycle valid strobe, plus parity and stop (framing) error pulses.

Parameters:
DATA_LENGTH, 8, number of data bits per frame (1..16).
OVERSAMPLE, 8, CLK cycles per bit period; even, >= 4.

Ports:
CLK  input  1  oversampling clock; all logic on rising edge.
RST  input  1  synchronous reset, active-high.
RX_IN  input  1  asynchronous serial line; idles high.
PAR_EN  input  1  1 = frame carries a parity bit.
PAR_TYP  input  1  0 = even parity, 1 = odd parity.
P_DATA  output  DATA_LENGTH  last correctly received word.
DATA_VALID  output  1  one-cycle pulse when P_DATA is updated.
PAR_ERR  output  1  one-cycle pulse on parity mismatch.
STP_ERR  output  1  one-cycle pulse when the stop bit is sampled 0.
BUSY  output  1  high while a frame is being received.

Behaviour:
- Interface: one clock, CLK. Reset RST is synchronous and active-high.
- Reset (any state, including mid-frame):
  - FSM goes to IDLE and all counters clear.
  - Both synchroniser flops are set to 1.
  - P_DATA=0, DATA_VALID=0, PAR_ERR=0, STP_ERR=0, BUSY=0.
- Synchroniser: RX_IN passes through a 2-flop synchroniser. A level change sampled at edge e is seen by the FSM at edge e+2. All timing below uses the synchronised line (rx_s).
- FSM states: IDLE, START, DATA, PARITY, STOP.
- Bit timing:
  - Cycle 0 is the edge at which IDLE samples rx_s=0.
  - Bit k spans cycles k*OVERSAMPLE .. k*OVERSAMPLE+OVERSAMPLE-1.
  - Each bit is sampled at offsets OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit value is the 2-of-3 majority, decided at offset OVERSAMPLE/2+1.
- IDLE: BUSY=0. On rx_s=0, go to START; PAR_EN and PAR_TYP are latched on this edge.
- START: if the majority is 1 (glitch), return to IDLE on the next edge with no output pulse. Otherwise go to DATA at the bit boundary.
- DATA: shift bits in LSB first; a bit counter runs 0..DATA_LENGTH-1. After the last bit, go to PARITY if the latched PAR_EN=1, else to STOP.
- PARITY: expected bit = XOR of the data bits, inverted when the latched PAR_TYP=1. A mismatch sets an internal parity-fail flag.
- STOP: at the decision offset, go to IDLE. On the following cycle (already in IDLE):
  - stop majority 0 -> STP_ERR=1;
  - parity-fail flag set -> PAR_ERR=1;
  - neither error -> DATA_VALID=1 and P_DATA is loaded with the shifted word.
  - Both errors may pulse together.
  - DATA_VALID is never asserted together with an error.
  - The remainder of the stop bit is spent in IDLE, giving resync margin for back-to-back frames.
- BUSY: 1 in START, DATA, PARITY and STOP, from the edge after cycle 0 until the edge that enters IDLE.
- P_DATA holds its value between DATA_VALID pulses and is unchanged by errored frames.
- Latency: DATA_VALID is high in the cycle after FSM edge (1+DATA_LENGTH+PAR_EN)*OVERSAMPLE + OVERSAMPLE/2+1.
  - With the defaults and no parity: FSM edge 77, raw-input edge 79; the pulse is visible after raw edge 80.
  - With parity: +OVERSAMPLE cycles.
- Line held low (break): each frame produces STP_ERR, then IDLE immediately re-detects a start. No lockup.
- PAR_EN/PAR_TYP changes mid-frame do not affect the current frame.

Test Plan:
1. Reset, then send 0xA5 with no parity, bits 8 CLK wide -> single DATA_VALID pulse 80 edges after the raw start falling edge; P_DATA=0xA5; PAR_ERR=STP_ERR=0; BUSY high for the frame, low after.
2. PAR_EN=1, PAR_TYP=0, send 0x3C with parity bit 0 -> DATA_VALID, P_DATA=0x3C. Repeat with parity bit 1 -> PAR_ERR pulse only, P_DATA remains 0x3C.
3. PAR_EN=1, PAR_TYP=1, send 0x01 with parity 0 -> DATA_VALID, P_DATA=0x01. Then send 0x55 with stop bit 0 -> STP_ERR pulse, no DATA_VALID, P_DATA=0x01.
4. Start glitch: RX_IN low for 3 cycles, then high -> BUSY pulses, FSM returns to IDLE, no output pulses. A following frame 0x7E is received correctly.
5. Back-to-back frames 0x12, 0x34 with one stop bit each, plus a single-cycle glitch inside data bit 3 of the second frame -> two DATA_VALID pulses with 0x12 then 0x34 (majority vote rejects the glitch).
6. Assert RST in the middle of DATA of a 0xFF frame -> the next edge shows BUSY=0 and all outputs 0. A fresh frame 0x81 afterwards yields P_DATA=0x81.
